lp_filter_arb: RTL and testbench

- Shares one first-order low-pass IIR datapath (accumulator with saturation, time constant 8 ns·2^(tau+6)) among NCH independent channels.
- A round-robin arbiter grants one channel per clk cycle.
- Per-channel accumulator state is held in a register array, and the result is written back through a 2-stage pipeline.
- Sits between the lock-in demodulator outputs and the PID inputs. It replaces NCH separate filter instances when the channel sample rate is ≤ clk/NCH.

---
 rtl/lp_filter_arb.sv | 144 ++++++++++++++
 tb/tb_lp_filter_arb.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lp_filter_arb.sv
// lp_filter_arb: NCH-channel time-shared first-order IIR low-pass with a round-robin front end.
// Define LP_FILTER_ARB_CLEAR_EN to add the per-channel clr port.

module lp_filter_arb_lane #(
    parameter int R = 14,
    parameter int S = 49
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic [S-1:0] wsum,
    input  logic [R-1:0] wout,
    output logic [S-1:0] sum,
    output logic [R-1:0] out_data,
    output logic         out_valid
);
    // clr beats a same-edge write so a cleared channel restarts from zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= we;
            if (we) begin
                sum      <= wsum;
                out_data <= wout;
            end
        end
    end
endmodule

module lp_filter_arb #(
    parameter int NCH = 4,
    parameter int R   = 14,
    parameter int S   = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6*NCH-1:0] tau,
    input  logic [R*NCH-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
`ifdef LP_FILTER_ARB_CLEAR_EN
    input  logic [NCH-1:0]   clr,
`endif
    output logic [NCH-1:0]   in_ready,
    output logic [R*NCH-1:0] out_data,
    output logic [NCH-1:0]   out_valid
);
    localparam int CW = $clog2(NCH);

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [R-1:0]  smp;
        logic [5:0]    tau;
    } req_t;

    logic [NCH-1:0]        clr_i, req;
    logic [CW-1:0]         ptr, gnt_ch;
    logic                  gnt_any;
    logic [1:0]            vld_pipe;
    req_t                  s0, s1;
    logic signed [S-1:0]   s1_sum, rd_sum, decay, newsum, nshift;
    logic [S:0]            sn;
    logic [R-1:0]          wout;
    logic [NCH-1:0][S-1:0] sum_q;

`ifdef LP_FILTER_ARB_CLEAR_EN
    assign clr_i = clr;
`else
    assign clr_i = '0;
`endif
    assign req = in_valid & ~clr_i;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = CW'(idx);
            end
        end
        if (rst) gnt_any = 1'b0;
        in_ready = gnt_any ? (NCH'(1) << gnt_ch) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], gnt_any};
            if (gnt_any) ptr <= (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
        end
    end

    // Payload needs no reset; vld_pipe qualifies it
    always_ff @(posedge clk) begin
        s0.ch  <= gnt_ch;
        s0.smp <= in_data[gnt_ch*R +: R];
        s0.tau <= tau[gnt_ch*6 +: 6];
        s1     <= s0;
        s1_sum <= rd_sum;
    end

    // Forward the stage-2 result when it targets the channel being read
    always_comb begin
        rd_sum = sum_q[s0.ch];
        if (vld_pipe[1] && s1.ch == s0.ch) rd_sum = newsum;
        if (clr_i[s0.ch]) rd_sum = '0;
    end

    always_comb begin
        decay = (s1_sum >>> 6) >>> s1.tau[3:0];
        sn    = {{(S+1-R){s1.smp[R-1]}}, s1.smp} + {s1_sum[S-1], s1_sum} - {decay[S-1], decay};
        case (sn[S:S-1])
            2'b01:   newsum = {1'b0, {(S-1){1'b1}}};
            2'b10:   newsum = {1'b1, {(S-1){1'b0}}};
            default: newsum = sn[S-1:0];
        endcase
        nshift = (newsum >>> 6) >>> s1.tau[3:0];
        wout   = (s1.tau[5:4] != 2'b00) ? s1.smp : nshift[R-1:0];
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        lp_filter_arb_lane #(.R(R), .S(S)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_i[i]),
            .we        (vld_pipe[1] && s1.ch == CW'(i)),
            .wsum      (newsum),
            .wout      (wout),
            .sum       (sum_q[i]),
            .out_data  (out_data[i*R +: R]),
            .out_valid (out_valid[i])
        );
    end
endmodule

// File: tb/tb_lp_filter_arb.sv
// Directed bench for lp_filter_arb: latency, forwarding, fairness, bypass, saturation, reset.
// A second instance with S=20 covers accumulator clamping.

module tb_lp_filter_arb;
    localparam int NCH = 4;
    localparam int R   = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic [6*NCH-1:0] tau, tau2;
    logic [R*NCH-1:0] din, din2, od, od2;
    logic [NCH-1:0]   iv, iv2, rdy, rdy2, ov, ov2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lp_filter_arb #(.NCH(NCH), .R(R), .S(49)) u_dut (
        .clk(clk), .rst(rst), .tau(tau), .in_data(din), .in_valid(iv),
        .in_ready(rdy), .out_data(od), .out_valid(ov)
    );

    lp_filter_arb #(.NCH(NCH), .R(R), .S(20)) u_sat (
        .clk(clk), .rst(rst), .tau(tau2), .in_data(din2), .in_valid(iv2),
        .in_ready(rdy2), .out_data(od2), .out_valid(ov2)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint chv(input logic [R*NCH-1:0] v, input int i);
        logic signed [R-1:0] t;
        t = v[i*R +: R];
        return longint'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NCH-1:0] exp_gnt [8];
        longint cur, prev;
        bit neg, mono;

        rst = 1'b1; tau = '0; din = '0; iv = 4'hF;
        tau2 = '0; din2 = '0; iv2 = '0;
        tick(); tick();
        chk("rst_ready", rdy, 0);
        chk("rst_ovalid", ov, 0);
        chk("rst_odata", od, 0);
        iv = '0; rst = 1'b0;
        tick();

        // single channel stream, back-to-back forwarding
        din[0*R +: R] = 14'd100; iv = 4'b0001;
        #1 chk("t1_ready", rdy, 4'b0001);
        tick(); tick();
        chk("t1_latency", ov, 0);
        tick();
        chk("t1_out0", chv(od, 0), 1);
        chk("t1_ov0", ov, 4'b0001);
        tick(); chk("t1_out1", chv(od, 0), 3);
        tick(); chk("t1_out2", chv(od, 0), 4);
        repeat (1000) tick();
        chk("t1_conv", chv(od, 0), 100);
        chk("t1_ovhold", ov, 4'b0001);
        iv = '0;
        repeat (3) tick();

        // fairness, then ch1 drops out
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NCH; i++) din[i*R +: R] = 14'd10;
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
        iv = 4'hF;
        for (int j = 0; j < 8; j++) begin
            if (j == 4) iv = 4'b1101;
            #1;
            chk($sformatf("rr_ready%0d", j), rdy, exp_gnt[j]);
            if (j >= 3) chk($sformatf("rr_ovalid%0d", j), ov, exp_gnt[j-3]);
            tick();
        end
        iv = '0;
        repeat (3) tick();

        // bypass, then resume filtering from accumulated sum
        rst = 1'b1; tick(); rst = 1'b0;
        tau[3*6 +: 6] = 6'd16; din[3*R +: R] = -14'sd500; iv = 4'b1000;
        tick(); iv = '0;
        tick(); chk("byp_latency", ov, 0);
        tick();
        chk("byp_out", chv(od, 3), -500);
        chk("byp_ov", ov, 4'b1000);
        tau[3*6 +: 6] = 6'd0; iv = 4'b1000;
        tick(); iv = '0;
        tick(); tick();
        chk("byp_resume", chv(od, 3), -16);

        // saturation on the narrow accumulator
        tau2[0*6 +: 6] = 6'd3; din2[0*R +: R] = 14'd8191; iv2 = 4'b0001;
        neg = 1'b0;
        repeat (300) begin
            tick();
            if (chv(od2, 0) < 0) neg = 1'b1;
        end
        chk("sat_out", chv(od2, 0), 1023);
        chk("sat_noneg", neg, 0);
        din2[0*R +: R] = -14'sd8192;
        tick(); tick(); tick();
        chk("sat_first_down", chv(od2, 0), 1006);
        prev = 1006; mono = 1'b1;
        repeat (300) begin
            tick();
            cur = chv(od2, 0);
            if (cur > prev) mono = 1'b0;
            prev = cur;
        end
        chk("sat_mono", mono, 1);
        chk("sat_neg_clamp", chv(od2, 0), -1024);
        iv2 = '0;

        // reset one cycle after accepting ch2
        din[2*R +: R] = 14'd6400; iv = 4'b0100;
        tick(); iv = '0; rst = 1'b1;
        tick(); chk("rmid_ov_a", ov, 0);
        tick(); chk("rmid_ov_b", ov, 0);
        rst = 1'b0;
        tick();
        chk("rmid_ov_c", ov, 0);
        chk("rmid_odata", od, 0);
        iv = 4'hF;
        #1 chk("rmid_ptr", rdy, 4'b0001);
        din[2*R +: R] = 14'd64; iv = 4'b0100;
        tick(); iv = '0;
        tick(); tick();
        chk("rmid_fresh", chv(od, 2), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
